mux_vec_gen: RTL and testbench
==============================

// Module: mux_vec_gen
// PURPOSE
//   Self-test sequencer for 2:1 mux variants. On start it drives all 8 {sel,in1,in0} vectors
//   in ascending order and holds each for a settle window. It then samples up to NUM_OUT mux
//   outputs, compares each against the golden value sel?in1:in0, and counts failing vectors.
//   Sits upstream of the mux instances (feeds sel/in1/in0) and consumes their y outputs.
// PARAMETERS
//   HOLD_CYC  4  settle cycles per vector before sampling; legal range >= 1
//   NUM_OUT   3  number of mux outputs checked in parallel
//   ERR_W     4  width of err_cnt; saturates at all-ones
// PORTS
//   clk       in   1        rising-edge clock
//   rst_n     in   1        asynchronous, active-low reset
//   start     in   1        begin a sweep; sampled only in IDLE, ignored while busy
//   sel       out  1        mux select stimulus      (= vec_idx[2])
//   in1       out  1        mux data-1 stimulus      (= vec_idx[1])
//   in0       out  1        mux data-0 stimulus      (= vec_idx[0])
//   y         in   NUM_OUT  outputs of the muxes under test
//   vec_idx   out  3        current vector index 0..7
//   busy      out  1        high from start acceptance until FINISH inclusive
//   err_valid out  1        1-cycle pulse in SAMPLE when any y bit mismatches
//   err_mask  out  NUM_OUT  sticky OR of mismatching y bits over the sweep
//   err_cnt   out  ERR_W    number of vectors with >=1 mismatch; saturating
//   done      out  1        1-cycle pulse in FINISH
//   pass      out  1        (err_cnt==0) latched in FINISH; held until next start
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; vec_idx=0; all outputs 0; settle counter 0.
//   All outputs are registered. {sel,in1,in0} always equals vec_idx.
//   FSM IDLE -> SETTLE -> SAMPLE -> (SETTLE | FINISH) -> IDLE:
//     IDLE:   start=1 -> vec_idx<=0, cnt<=HOLD_CYC, clear err_cnt/err_mask/pass, busy<=1.
//     SETTLE: cnt decrements each cycle. Leave when cnt==1 -> SAMPLE (exactly HOLD_CYC cycles).
//     SAMPLE: exp=sel?in1:in0. mis = y ^ {NUM_OUT{exp}}. err_mask |= mis.
//             If |mis: err_valid=1 and err_cnt+1 (held at max).
//             If vec_idx==7 -> FINISH; else vec_idx+1, cnt<=HOLD_CYC, -> SETTLE.
//     FINISH: done=1, pass<=(err_cnt==0), busy<=0 on exit -> IDLE.
//   Latency: done asserts 8*(HOLD_CYC+1) clocks after the start-accepting edge.
//   Each vector is stable for HOLD_CYC+1 cycles.
//   start held high through FINISH: new sweep begins on the first IDLE cycle. No start queueing.
//   In IDLE the last vector (7 after a sweep) stays driven; err_mask/err_cnt/pass are held.
//   Reset mid-sweep: immediate abort to reset values; no done pulse.
//   A y value of X/Z counts as a mismatch in simulation (compare with !==).
// STRUCTURE
//   Shared package mux_tb_pkg holds:
//     state enum {IDLE,SETTLE,SAMPLE,FINISH}
//     VEC_W=3 and VEC_LAST=3'd7
//     function mux_golden(sel,in1,in0)
//   Single sub-module mux_vec_cmp (combinational): y, exp -> mis, any_mis.
//   The FSM, counter and vector register stay in the top.
// TESTING
//   1 Three correct muxes on y, HOLD_CYC=4, start pulse:
//     done at +40 clk, pass=1, err_cnt=0, err_mask=3'b000.
//   2 y[1] tied 0: err_valid on vectors 1,3,6,7 -> err_cnt=4, err_mask=3'b010, pass=0.
//   3 y[0] = in0 (sel ignored): failures on vectors 5,6 -> err_cnt=2, err_mask=3'b001.
//   4 rst_n low while vec_idx=3:
//     all outputs 0 immediately, no done pulse.
//     Next start sweeps from vec_idx=0 with a cleared err_cnt.
//   5 start pulsed during SETTLE of vector 2: ignored, single done.
//     start held high: back-to-back sweeps with one IDLE cycle between.
//   6 HOLD_CYC=1, ERR_W=2, all y inverted:
//     done at +16 clk, err_cnt saturates at 3, err_mask=all ones.

Source files
------------

// File: rtl/mux_tb_pkg.sv
// Shared types and helpers for the 2:1 mux self-test sequencer.
package mux_tb_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

  localparam int VEC_W = 3;
  localparam logic [VEC_W-1:0] VEC_LAST = 3'd7;

  function automatic logic mux_golden(input logic sel, input logic in1, input logic in0);
    return sel ? in1 : in0;
  endfunction

endpackage

// File: rtl/mux_vec_cmp.sv
// Compares NUM_OUT mux outputs against one golden bit; combinational, no backpressure.
module mux_vec_cmp #(
  parameter int NUM_OUT = 3
) (
  input  logic [NUM_OUT-1:0] y,
  input  logic               exp_bit,
  output logic [NUM_OUT-1:0] mis,
  output logic               any_mis
);

  // Case-inequality so an undriven (X/Z) output is flagged rather than propagated.
  always_comb begin
    mis = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      mis[i] = (y[i] !== exp_bit);
    end
    any_mis = |mis;
  end

endmodule

// File: rtl/mux_vec_gen.sv
// Sweeps all 8 {sel,in1,in0} vectors into the muxes under test, checks their outputs
// after a settle window and reports failing vectors; done arrives 8*(HOLD_CYC+1) clocks after start.
module mux_vec_gen
  import mux_tb_pkg::*;
#(
  parameter int HOLD_CYC = 4,
  parameter int NUM_OUT  = 3,
  parameter int ERR_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               sel,
  output logic               in1,
  output logic               in0,
  input  logic [NUM_OUT-1:0] y,
  output logic [VEC_W-1:0]   vec_idx,
  output logic               busy,
  output logic               err_valid,
  output logic [NUM_OUT-1:0] err_mask,
  output logic [ERR_W-1:0]   err_cnt,
  output logic               done,
  output logic               pass
);

  localparam int CNT_W = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               exp_bit;
  logic [NUM_OUT-1:0] mis;
  logic               any_mis;

  // The stimulus bits are the vector register itself, so they stay registered.
  assign sel = vec_idx[2];
  assign in1 = vec_idx[1];
  assign in0 = vec_idx[0];

  assign exp_bit = mux_golden(sel, in1, in0);

  mux_vec_cmp #(.NUM_OUT(NUM_OUT)) u_cmp (
    .y       (y),
    .exp_bit (exp_bit),
    .mis     (mis),
    .any_mis (any_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      vec_idx   <= '0;
      busy      <= 1'b0;
      err_valid <= 1'b0;
      err_mask  <= '0;
      err_cnt   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec_idx  <= '0;
            cnt      <= CNT_W'(HOLD_CYC);
            err_cnt  <= '0;
            err_mask <= '0;
            pass     <= 1'b0;
            busy     <= 1'b1;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= SAMPLE;
        end
        SAMPLE: begin
          err_mask <= err_mask | mis;
          if (any_mis) begin
            err_valid <= 1'b1;
            if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
          end
          if (vec_idx == VEC_LAST) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            vec_idx <= vec_idx + VEC_W'(1);
            cnt     <= CNT_W'(HOLD_CYC);
            state   <= SETTLE;
          end
        end
        FINISH: begin
          pass  <= (err_cnt == '0);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_vec_gen.sv
// Bench for mux_vec_gen: table of sweeps with modelled faulty muxes, plus reset/start/saturation sequences.
module tb_mux_vec_gen;

  logic       clk = 1'b0;
  logic       rst_n, start, start2;
  logic       sel, in1, in0, sel2, in1_2, in0_2;
  logic [2:0] y, y2, vec_idx, vec_idx2, err_mask, err_mask2;
  logic       busy, err_valid, done, pass;
  logic       busy2, err_valid2, done2, pass2;
  logic [3:0] err_cnt;
  logic [1:0] err_cnt2;
  int         mode;

  always #5 clk = ~clk;

  mux_vec_gen u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .in1(in1), .in0(in0), .y(y),
    .vec_idx(vec_idx), .busy(busy), .err_valid(err_valid), .err_mask(err_mask),
    .err_cnt(err_cnt), .done(done), .pass(pass)
  );

  mux_vec_gen #(.HOLD_CYC(1), .NUM_OUT(3), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sel(sel2), .in1(in1_2), .in0(in0_2), .y(y2),
    .vec_idx(vec_idx2), .busy(busy2), .err_valid(err_valid2), .err_mask(err_mask2),
    .err_cnt(err_cnt2), .done(done2), .pass(pass2)
  );

  // Mux models: 0 correct, 1 y[1] stuck at 0, 2 y[0] ignores sel, 3 all inverted.
  function automatic logic [2:0] ymodel(input int m, input logic s, input logic a, input logic b);
    logic [2:0] g;
    g = {3{s ? a : b}};
    case (m)
      1:       g[1] = 1'b0;
      2:       g[0] = b;
      3:       g = ~g;
      default: ;
    endcase
    return g;
  endfunction

  always_comb y  = ymodel(mode, sel, in1, in0);
  always_comb y2 = ymodel(3, sel2, in1_2, in0_2);

  typedef struct {
    logic [3:0] cnt;
    logic [2:0] mask;
    logic       p;
  } fin_t;

  typedef struct {
    int         m;
    int         lat;
    logic [3:0] cnt;
    logic [2:0] mask;
    logic       p;
  } vec_t;

  fin_t       fin_q[$];
  logic [2:0] err_q[$];
  int         n_chk = 0, n_fail = 0, done_cnt = 0, ev2_cnt = 0;
  logic       pend_pass = 1'b0, exp_pass = 1'b0;
  fin_t       f_rec;
  logic [2:0] e_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Golden sweep model: failing vectors and final result for a given mux model.
  task automatic push_sweep(input int m);
    logic [3:0] c;
    logic [2:0] mk, mis, vv;
    logic       e;
    c  = '0;
    mk = '0;
    for (int v = 0; v < 8; v++) begin
      vv  = v[2:0];
      e   = vv[2] ? vv[1] : vv[0];
      mis = ymodel(m, vv[2], vv[1], vv[0]) ^ {3{e}};
      if (mis != 3'b000) begin
        // err_valid is seen after the sample edge, when vec_idx has already advanced.
        err_q.push_back((v == 7) ? 3'd7 : 3'(v + 1));
        if (c != 4'hf) c = c + 4'd1;
      end
      mk = mk | mis;
    end
    fin_q.push_back('{cnt: c, mask: mk, p: (c == 4'd0)});
  endtask

  always @(negedge clk) begin
    if (pend_pass) begin
      chk("sb_pass", 32'(pass), 32'(exp_pass));
      pend_pass = 1'b0;
    end
    if (rst_n && err_valid2 === 1'b1) ev2_cnt++;
    if (rst_n && err_valid === 1'b1) begin
      if (err_q.size() == 0) chk("sb_err_valid_unexpected", 32'(vec_idx), 32'hffff);
      else begin
        e_idx = err_q.pop_front();
        chk("sb_err_vec", 32'(vec_idx), 32'(e_idx));
      end
    end
    if (rst_n && done === 1'b1) begin
      done_cnt++;
      if (fin_q.size() == 0) chk("sb_done_unexpected", 32'(done_cnt), 32'hffff);
      else begin
        f_rec = fin_q.pop_front();
        chk("sb_err_cnt", 32'(err_cnt), 32'(f_rec.cnt));
        chk("sb_err_mask", 32'(err_mask), 32'(f_rec.mask));
        chk("sb_err_left", 32'(err_q.size()), 32'd0);
        exp_pass  = f_rec.p;
        pend_pass = 1'b1;
      end
    end
  end

  task automatic sweep(input vec_t t);
    int k;
    mode = t.m;
    push_sweep(t.m);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_on_accept", 32'(busy), 32'd1);
    chk("vec_on_accept", 32'(vec_idx), 32'd0);
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk); k++;
    end
    chk("done_latency", 32'(k), 32'(t.lat));
    chk("busy_in_finish", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    chk("err_cnt", 32'(err_cnt), 32'(t.cnt));
    chk("err_mask", 32'(err_mask), 32'(t.mask));
    chk("pass", 32'(pass), 32'(t.p));
    chk("vec_idle", 32'(vec_idx), 32'd7);
  endtask

  task automatic wait_vec(input logic [2:0] v);
    int k;
    k = 0;
    while (vec_idx !== v && k < 200) begin
      @(negedge clk); k++;
    end
    chk("wait_vec_timeout", 32'(vec_idx), 32'(v));
  endtask

  initial begin
    vec_t tbl[3];
    int   k, d0;
    tbl[0] = '{m: 0, lat: 40, cnt: 4'd0, mask: 3'b000, p: 1'b1};
    tbl[1] = '{m: 1, lat: 40, cnt: 4'd4, mask: 3'b010, p: 1'b0};
    tbl[2] = '{m: 2, lat: 40, cnt: 4'd2, mask: 3'b001, p: 1'b0};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'({vec_idx, busy, err_valid, err_mask, err_cnt, done, pass}), 32'd0);
    chk("rst_state2", 32'({vec_idx2, busy2, err_valid2, err_mask2, err_cnt2, done2, pass2}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) sweep(tbl[i]);

    // Reset mid-sweep with an error already counted.
    mode = 1;
    push_sweep(1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_vec(3'd3);
    chk("cnt_before_rst", 32'(err_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_abort", 32'({vec_idx, sel, in1, in0, busy, err_valid, err_mask, err_cnt, done, pass}), 32'd0);
    err_q.delete();
    fin_q.delete();
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    sweep(tbl[0]);

    // Start pulse while busy is ignored.
    mode = 0;
    push_sweep(0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    d0 = done_cnt;
    wait_vec(3'd2);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (80) @(negedge clk);
    chk("single_done", 32'(done_cnt - d0), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);

    // Start held high: back-to-back sweeps with one IDLE cycle between.
    push_sweep(0);
    push_sweep(0);
    @(negedge clk); start = 1'b1;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk); k++;
    end
    chk("held_first_done", 32'(k), 32'd41);
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (done !== 1'b1 && k < 200);
    start = 1'b0;
    chk("held_gap", 32'(k), 32'd42);
    repeat (4) @(negedge clk);
    chk("held_stop", 32'(busy), 32'd0);
    chk("sb_drained", 32'(fin_q.size() + err_q.size()), 32'd0);

    // Short hold, narrow saturating counter, every output wrong.
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    k = 0;
    while (done2 !== 1'b1 && k < 200) begin
      @(negedge clk); k++;
    end
    chk("h1_latency", 32'(k), 32'd16);
    chk("h1_err_cnt_sat", 32'(err_cnt2), 32'd3);
    chk("h1_err_mask", 32'(err_mask2), 32'd7);
    @(negedge clk);
    chk("h1_pass", 32'(pass2), 32'd0);
    chk("h1_busy", 32'(busy2), 32'd0);
    chk("h1_err_pulses", 32'(ev2_cnt), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
